// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-side controller:
// forward-code bit positions, write-port source encoding and queue sizing helpers.
package regfile_writeback_pkg;

  localparam int FORWARD_COLLISION_IN_ID = 0;
  localparam int FORWARD_PENDING_LONG    = 1;
  localparam int FORWARD_SRC_LONG        = 2;
  localparam int FORWARD_CODE_WIDTH      = 3;

  typedef enum logic [1:0] {
    WR_SRC_NONE,
    WR_SRC_PIPE,
    WR_SRC_QUEUE,
    WR_SRC_THROUGH
  } wr_src_t;

  function automatic logic is_long_src(input wr_src_t src);
    return (src == WR_SRC_QUEUE) || (src == WR_SRC_THROUGH);
  endfunction

  function automatic int lq_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int lq_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_writeback_lq_fifo.sv
// Small synchronous FIFO holding long-latency completions until the write port is free.
// Storage is not reset; only the pointers and occupancy count are.
module wb_lq_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                               cpu_clk,
  input  logic                               cpu_rst_n,
  input  logic                               push,
  input  logic [WIDTH-1:0]                   push_data,
  input  logic                               pop,
  output logic [WIDTH-1:0]                   head,
  output logic [lq_count_width(DEPTH)-1:0]   count,
  output logic                               full
);

  localparam int PTR_W = lq_ptr_width(DEPTH);
  localparam int CNT_W = lq_count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
  assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/regfile_writeback.sv
// Write-side controller: arbitrates pipeline writeback and long-latency completions onto
// the single register-file write port, and tracks outstanding long-latency destinations.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int REGISTER_WIDTH      = 32,
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int LQ_DEPTH            = 2
) (
  input  logic                           cpu_clk,
  input  logic                           cpu_rst_n,
  input  logic                           wb_valid,
  input  logic [REGISTER_ADDR_WIDTH-1:0] wb_addr,
  input  logic [REGISTER_WIDTH-1:0]      wb_data,
  input  logic                           lu_issue,
  input  logic [REGISTER_ADDR_WIDTH-1:0] lu_issue_addr,
  input  logic                           lu_valid,
  output logic                           lu_ready,
  input  logic [REGISTER_ADDR_WIDTH-1:0] lu_addr,
  input  logic [REGISTER_WIDTH-1:0]      lu_data,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_addr,
  output logic [2:0]                     forward_detect_rs1,
  output logic [2:0]                     forward_detect_rs2,
  output logic                           we,
  output logic [REGISTER_ADDR_WIDTH-1:0] wd_addr,
  output logic [REGISTER_WIDTH-1:0]      wd_data
);

  localparam int NUM_REGS = 1 << REGISTER_ADDR_WIDTH;
  localparam int ENTRY_W  = REGISTER_ADDR_WIDTH + REGISTER_WIDTH;
  localparam int CNT_W    = lq_count_width(LQ_DEPTH);

  logic [ENTRY_W-1:0]             lq_head;
  logic [CNT_W-1:0]               lq_count;
  logic                           lq_full;
  logic                           lq_empty;
  logic                           lq_push;
  logic                           lq_pop;
  logic [REGISTER_ADDR_WIDTH-1:0] head_addr;
  logic [REGISTER_WIDTH-1:0]      head_data;

  wr_src_t                        wr_src;
  logic [REGISTER_ADDR_WIDTH-1:0] sel_addr;
  logic [REGISTER_WIDTH-1:0]      sel_data;
  logic                           long_write;
  logic                           wb_write;
  logic                           lu_live;

  logic [NUM_REGS-1:0]            pending;
  logic [NUM_REGS-1:0]            pending_next;

  assign head_addr = lq_head[ENTRY_W-1 -: REGISTER_ADDR_WIDTH];
  assign head_data = lq_head[REGISTER_WIDTH-1:0];
  assign lq_empty  = (lq_count == '0);

  assign wb_write  = wb_valid && (wb_addr != '0);
  assign lu_live   = lu_valid && (lu_addr != '0);
  assign lu_ready  = cpu_rst_n && !lq_full;

  // Pipeline wins, then the oldest queued completion, then a write-through of a fresh one.
  always_comb begin
    wr_src   = WR_SRC_NONE;
    sel_addr = '0;
    sel_data = '0;
    if (wb_write) begin
      wr_src   = WR_SRC_PIPE;
      sel_addr = wb_addr;
      sel_data = wb_data;
    end else if (!lq_empty) begin
      wr_src   = WR_SRC_QUEUE;
      sel_addr = head_addr;
      sel_data = head_data;
    end else if (lu_live) begin
      wr_src   = WR_SRC_THROUGH;
      sel_addr = lu_addr;
      sel_data = lu_data;
    end
  end

  assign long_write = is_long_src(wr_src);
  assign lq_pop     = (wr_src == WR_SRC_QUEUE);
  // Completions to x0 are accepted but never stored.
  assign lq_push    = lu_live && lu_ready && (wr_src != WR_SRC_THROUGH);

  assign we      = cpu_rst_n && (wr_src != WR_SRC_NONE);
  assign wd_addr = cpu_rst_n ? sel_addr : '0;
  assign wd_data = cpu_rst_n ? sel_data : '0;

  wb_lq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .push      (lq_push),
    .push_data ({lu_addr, lu_data}),
    .pop       (lq_pop),
    .head      (lq_head),
    .count     (lq_count),
    .full      (lq_full)
  );

  // Clear is applied before set so a re-issue in the draining cycle keeps the bit.
  always_comb begin
    pending_next = pending;
    if (long_write) pending_next[sel_addr] = 1'b0;
    if (lu_issue && (lu_issue_addr != '0)) pending_next[lu_issue_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) pending <= '0;
    else            pending <= pending_next;
  end

  function automatic logic [FORWARD_CODE_WIDTH-1:0] forward_code(
    input logic [REGISTER_ADDR_WIDTH-1:0] rs,
    input logic                           pend_bit,
    input logic                           port_we,
    input logic [REGISTER_ADDR_WIDTH-1:0] port_addr,
    input logic                           port_long
  );
    logic [FORWARD_CODE_WIDTH-1:0] code;
    code = '0;
    code[FORWARD_COLLISION_IN_ID] = port_we && (port_addr == rs) && (rs != '0);
    code[FORWARD_PENDING_LONG]    = pend_bit && !(port_long && (port_addr == rs));
    code[FORWARD_SRC_LONG]        = code[FORWARD_COLLISION_IN_ID] && port_long;
    return code;
  endfunction

  assign forward_detect_rs1 = forward_code(rs1_addr, pending[rs1_addr], we, wd_addr, long_write);
  assign forward_detect_rs2 = forward_code(rs2_addr, pending[rs2_addr], we, wd_addr, long_write);

  // Issuing-side protocol checks; an issue to an address drained this same cycle is legal.
  a_issue_not_pending: assert property (@(posedge cpu_clk) disable iff (!cpu_rst_n)
    (lu_issue && (lu_issue_addr != '0) && !(long_write && (sel_addr == lu_issue_addr)))
      |-> !pending[lu_issue_addr]);

  a_wb_not_pending: assert property (@(posedge cpu_clk) disable iff (!cpu_rst_n)
    wb_write |-> !pending[wb_addr]);

  a_lu_is_pending: assert property (@(posedge cpu_clk) disable iff (!cpu_rst_n)
    (lu_live && lu_ready) |-> pending[lu_addr]);

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic, all checked
// against a queue/array reference model of the write-port and scoreboard rules.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int LQ = 2;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [2:0]  forward_detect_rs1;
  logic [2:0]  forward_detect_rs2;
  logic        we;
  logic [4:0]  wd_addr;
  logic [31:0] wd_data;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } lq_ent_t;

  bit      pend [32];
  lq_ent_t lq [$];
  int      issued [$];

  bit          exp_we;
  bit [4:0]    exp_wa;
  bit [31:0]   exp_wd;
  bit          exp_ready;
  bit          exp_long;
  bit          exp_pop;
  bit          exp_thru;

  regfile_writeback dut (
    .cpu_clk            (cpu_clk),
    .cpu_rst_n          (cpu_rst_n),
    .wb_valid           (wb_valid),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data),
    .lu_issue           (lu_issue),
    .lu_issue_addr      (lu_issue_addr),
    .lu_valid           (lu_valid),
    .lu_ready           (lu_ready),
    .lu_addr            (lu_addr),
    .lu_data            (lu_data),
    .rs1_addr           (rs1_addr),
    .rs2_addr           (rs2_addr),
    .forward_detect_rs1 (forward_detect_rs1),
    .forward_detect_rs2 (forward_detect_rs2),
    .we                 (we),
    .wd_addr            (wd_addr),
    .wd_data            (wd_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                               input logic iss, input logic [4:0] issa,
                               input logic luv, input logic [4:0] lua, input logic [31:0] lud,
                               input logic [4:0] r1, input logic [4:0] r2);
    wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    lu_issue = iss; lu_issue_addr = issa;
    lu_valid = luv; lu_addr = lua; lu_data = lud;
    rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic applyIdle(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  function automatic logic [2:0] expCode(input logic [4:0] rs);
    logic [2:0] c;
    c = '0;
    c[FORWARD_COLLISION_IN_ID] = exp_we && (exp_wa == rs) && (rs != 0);
    c[FORWARD_PENDING_LONG]    = pend[rs] && !(exp_long && (exp_wa == rs));
    c[FORWARD_SRC_LONG]        = c[FORWARD_COLLISION_IN_ID] && exp_long;
    return c;
  endfunction

  task automatic modelEval();
    exp_ready = (lq.size() < LQ);
    exp_we = 0; exp_wa = 0; exp_wd = 0; exp_long = 0; exp_pop = 0; exp_thru = 0;
    if (wb_valid && wb_addr != 0) begin
      exp_we = 1; exp_wa = wb_addr; exp_wd = wb_data;
    end else if (lq.size() > 0) begin
      exp_we = 1; exp_wa = lq[0].addr; exp_wd = lq[0].data; exp_long = 1; exp_pop = 1;
    end else if (lu_valid && lu_addr != 0) begin
      exp_we = 1; exp_wa = lu_addr; exp_wd = lu_data; exp_long = 1; exp_thru = 1;
    end
  endtask

  task automatic modelCommit();
    lq_ent_t e;
    if (exp_pop) void'(lq.pop_front());
    if (lu_valid && exp_ready && lu_addr != 0) begin
      for (int i = 0; i < issued.size(); i++) begin
        if (issued[i] == int'(lu_addr)) begin
          issued.delete(i);
          break;
        end
      end
      if (!exp_thru) begin
        e.addr = lu_addr; e.data = lu_data;
        lq.push_back(e);
      end
    end
    if (exp_long) pend[exp_wa] = 0;
    if (lu_issue && lu_issue_addr != 0) begin
      pend[lu_issue_addr] = 1;
      issued.push_back(int'(lu_issue_addr));
    end
  endtask

  task automatic modelReset();
    lq.delete();
    issued.delete();
    foreach (pend[i]) pend[i] = 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_we"},       we,                 exp_we);
    checkOutput({tag, "_wd_addr"},  wd_addr,            exp_wa);
    checkOutput({tag, "_wd_data"},  wd_data,            exp_wd);
    checkOutput({tag, "_lu_ready"}, lu_ready,           exp_ready);
    checkOutput({tag, "_fd1"},      forward_detect_rs1, expCode(rs1_addr));
    checkOutput({tag, "_fd2"},      forward_detect_rs2, expCode(rs2_addr));
  endtask

  // Called at posedge+1 with inputs already applied; leaves time at the next posedge+1.
  task automatic runCycle(input string tag);
    @(negedge cpu_clk);
    modelEval();
    checkAll(tag);
    @(posedge cpu_clk);
    modelCommit();
    #1;
  endtask

  task automatic applyRandom();
    logic [4:0] a;
    logic       wbv, iss, luv;
    logic [4:0] wba, issa, lua, r1, r2;
    logic [31:0] lud;
    wbv = ($urandom_range(0, 1) == 1);
    wba = 5'($urandom_range(0, 31));
    if (pend[wba]) wba = 0;
    iss = 0;
    issa = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0 && !pend[issa]) iss = 1;
    luv = 0; lua = 0; lud = $urandom;
    if (issued.size() > 0 && $urandom_range(0, 1) == 1) begin
      luv = 1; lua = 5'(issued[0]);
    end else if ($urandom_range(0, 7) == 0) begin
      luv = 1; lua = 0;
    end
    a = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 2))
      0:       r1 = wba;
      1:       r1 = (issued.size() > 0) ? 5'(issued[0]) : a;
      default: r1 = a;
    endcase
    r2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31)) : lua;
    applyStimulus(wbv, wba, $urandom, iss, issa, luv, lua, lud, r1, r2);
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    applyIdle(0, 0);
    modelReset();
    #3;
    checkOutput("reset_we",       we,                 1'b0);
    checkOutput("reset_lu_ready", lu_ready,           1'b0);
    checkOutput("reset_fd1",      forward_detect_rs1, 3'b000);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk);
    #1;

    // Pipeline-only writes, including x0.
    applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0, 0, 5, 0);
    #1;
    checkOutput("pipe_we",      we,      1'b1);
    checkOutput("pipe_addr",    wd_addr, 5'd5);
    checkOutput("pipe_data",    wd_data, 32'h1234);
    checkOutput("pipe_col",     forward_detect_rs1[FORWARD_COLLISION_IN_ID], 1'b1);
    checkOutput("pipe_srclong", forward_detect_rs1[FORWARD_SRC_LONG], 1'b0);
    checkOutput("first_ready",  lu_ready, 1'b1);
    runCycle("pipe");
    applyStimulus(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("pipe_x0_we", we, 1'b0);
    runCycle("pipe_x0");

    // Long op written through.
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
    runCycle("issue7");
    applyIdle(0, 7);
    #1;
    checkOutput("pend7", forward_detect_rs2[FORWARD_PENDING_LONG], 1'b1);
    runCycle("pend7");
    applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'hAA, 0, 7);
    #1;
    checkOutput("thru_we",   we,      1'b1);
    checkOutput("thru_addr", wd_addr, 5'd7);
    checkOutput("thru_data", wd_data, 32'hAA);
    checkOutput("thru_code", forward_detect_rs2, 3'b101);
    runCycle("thru");
    applyIdle(0, 7);
    #1;
    checkOutput("clear7", forward_detect_rs2, 3'b000);
    runCycle("clear7");

    // Contention: two completions queue up behind pipeline writes.
    applyStimulus(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    runCycle("issue9");
    applyStimulus(0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
    runCycle("issue10");
    applyStimulus(1, 20, 32'h20, 0, 0, 1, 9, 32'h999, 9, 10);
    runCycle("cont1");
    applyStimulus(1, 21, 32'h21, 0, 0, 1, 10, 32'hA10, 9, 10);
    runCycle("cont2");
    applyStimulus(1, 22, 32'h22, 0, 0, 0, 0, 0, 9, 10);
    #1;
    checkOutput("cont_full_ready", lu_ready, 1'b0);
    runCycle("cont3");
    applyIdle(9, 10);
    #1;
    checkOutput("drain9_addr", wd_addr, 5'd9);
    checkOutput("drain9_data", wd_data, 32'h999);
    runCycle("drain9");
    applyIdle(9, 10);
    #1;
    checkOutput("drain10_addr", wd_addr,  5'd10);
    checkOutput("drain10_rdy",  lu_ready, 1'b1);
    runCycle("drain10");
    applyIdle(9, 10);
    runCycle("drained");

    // Same-cycle drain and re-issue of x3.
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    runCycle("issue3");
    applyStimulus(1, 23, 32'h23, 0, 0, 1, 3, 32'h33, 0, 0);
    runCycle("queue3");
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 3, 0);
    #1;
    checkOutput("setclr_addr", wd_addr, 5'd3);
    runCycle("setclr");
    applyIdle(3, 0);
    #1;
    checkOutput("setclr_pend", forward_detect_rs1[FORWARD_PENDING_LONG], 1'b1);
    runCycle("setclr_after");
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h44, 3, 0);
    runCycle("done3");

    // Reset mid-operation with a full queue and four pending bits.
    for (int i = 11; i <= 14; i++) begin
      applyStimulus(0, 0, 0, 1, 5'(i), 0, 0, 0, 0, 0);
      runCycle("issue_rst");
    end
    applyStimulus(1, 20, 32'h1, 0, 0, 1, 11, 32'hB11, 0, 0);
    runCycle("rstq1");
    applyStimulus(1, 21, 32'h2, 0, 0, 1, 12, 32'hB12, 0, 0);
    runCycle("rstq2");
    applyIdle(13, 14);
    #1;
    checkOutput("prerst_we",   we, 1'b1);
    checkOutput("prerst_fd1",  forward_detect_rs1, 3'b010);
    #1;
    cpu_rst_n = 1'b0;
    #1;
    checkOutput("inrst_we",    we,                 1'b0);
    checkOutput("inrst_addr",  wd_addr,            5'd0);
    checkOutput("inrst_data",  wd_data,            32'd0);
    checkOutput("inrst_ready", lu_ready,           1'b0);
    checkOutput("inrst_fd1",   forward_detect_rs1, 3'b000);
    checkOutput("inrst_fd2",   forward_detect_rs2, 3'b000);
    modelReset();
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk);
    #1;
    applyIdle(13, 14);
    #1;
    checkOutput("postrst_ready", lu_ready,           1'b1);
    checkOutput("postrst_we",    we,                 1'b0);
    checkOutput("postrst_fd1",   forward_detect_rs1, 3'b000);
    checkOutput("postrst_fd2",   forward_detect_rs2, 3'b000);
    runCycle("postrst");
    applyIdle(11, 12);
    runCycle("postrst2");

    // Randomized traffic within the issuing-side protocol.
    for (int n = 0; n < 600; n++) begin
      applyRandom();
      runCycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
